// File: rtl/seg_7_mux.sv
// rtl/seg_7_mux.sv - multiplexed 7-segment hex display driver
// Scans N_DIGITS digits from a per-scan snapshot, with optional leading-zero blanking.
module seg_7_mux #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int COMMON_ANODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg_7,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    digit_tick
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
    localparam logic INV = (COMMON_ANODE != 0);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] snap_val_q, snap_val_d;
    logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                  snap_blz_q, snap_blz_d;
    logic                  load_pend_q, load_pend_d;
    logic                  adv_q, adv_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  tick_q, tick_d;

    logic [4*N_DIGITS-1:0] src_val;
    logic [N_DIGITS-1:0]   src_dp;
    logic                  src_blz;
    logic                  wrap, nz, blank, dp_sel;
    logic [3:0]            nib;
    logic [6:0]            seg_act;
    logic                  dp_act;
    logic [N_DIGITS-1:0]   an_sel, an_act;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1111110;
            4'h1: hex7 = 7'b0110000;
            4'h2: hex7 = 7'b1101101;
            4'h3: hex7 = 7'b1111001;
            4'h4: hex7 = 7'b0110011;
            4'h5: hex7 = 7'b1011011;
            4'h6: hex7 = 7'b1011111;
            4'h7: hex7 = 7'b1110000;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1111011;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b0011111;
            4'hC: hex7 = 7'b1001110;
            4'hD: hex7 = 7'b0111101;
            4'hE: hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        presc_d     = presc_q;
        idx_d       = idx_q;
        snap_val_d  = snap_val_q;
        snap_dp_d   = snap_dp_q;
        snap_blz_d  = snap_blz_q;
        load_pend_d = load_pend_q;
        adv_d       = adv_q;
        tick_d      = 1'b0;
        seg_act     = 7'b0;
        dp_act      = 1'b0;
        an_act      = '0;

        // A pending load means the snapshot is stale; decode straight from the inputs.
        src_val = load_pend_q ? value    : snap_val_q;
        src_dp  = load_pend_q ? dp_in    : snap_dp_q;
        src_blz = load_pend_q ? blank_lz : snap_blz_q;

        nib    = 4'h0;
        dp_sel = 1'b0;
        nz     = 1'b0;
        an_sel = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (IW'(i) == idx_q) begin
                nib       = src_val[4*i +: 4];
                dp_sel    = src_dp[i];
                an_sel[i] = 1'b1;
            end
            if (IW'(i) >= idx_q && src_val[4*i +: 4] != 4'h0)
                nz = 1'b1;
        end
        blank = src_blz && (idx_q != '0) && !nz;

        wrap = (presc_q == PRESC_MAX);
        if (en) begin
            presc_d = wrap ? '0 : presc_q + 1'b1;
            adv_d   = wrap;
            if (wrap)
                idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            if (load_pend_q || (wrap && idx_q == IDX_MAX)) begin
                snap_val_d = value;
                snap_dp_d  = dp_in;
                snap_blz_d = blank_lz;
            end
            load_pend_d = 1'b0;
            tick_d      = adv_q || load_pend_q;
            if (!blank) begin
                seg_act = hex7(nib);
                dp_act  = dp_sel;
                an_act  = an_sel;
            end
        end

        seg_d = seg_act ^ {7{INV}};
        dp_d  = dp_act ^ INV;
        an_d  = an_act ^ {N_DIGITS{INV}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            snap_val_q  <= '0;
            snap_dp_q   <= '0;
            snap_blz_q  <= 1'b0;
            load_pend_q <= 1'b1;
            adv_q       <= 1'b0;
            seg_q       <= {7{INV}};
            dp_q        <= INV;
            an_q        <= {N_DIGITS{INV}};
            tick_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            snap_val_q  <= snap_val_d;
            snap_dp_q   <= snap_dp_d;
            snap_blz_q  <= snap_blz_d;
            load_pend_q <= load_pend_d;
            adv_q       <= adv_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            tick_q      <= tick_d;
        end
    end

    assign seg_7      = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign digit_tick = tick_q;

endmodule

// File: tb/tb_seg_7_mux.sv
// tb/tb_seg_7_mux.sv - directed self-checking bench for seg_7_mux
// A second instance with COMMON_ANODE=1 shares all inputs.
module tb_seg_7_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;

    logic [6:0]  seg_7, seg_ca;
    logic        dp, dp_ca;
    logic [3:0]  an, an_ca;
    logic        digit_tick, tick_ca;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_7_mux #(.N_DIGITS(4), .REFRESH_DIV(4), .COMMON_ANODE(0)) dut (
        .clk(clk), .rst(rst), .en(en), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg_7(seg_7), .dp(dp), .an(an), .digit_tick(digit_tick)
    );

    seg_7_mux #(.N_DIGITS(4), .REFRESH_DIV(4), .COMMON_ANODE(1)) dut_ca (
        .clk(clk), .rst(rst), .en(en), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg_7(seg_ca), .dp(dp_ca), .an(an_ca), .digit_tick(tick_ca)
    );

    task automatic apply_reset(input logic [15:0] v, input logic [3:0] d, input logic b);
        rst = 1'b1;
        en = 1'b0;
        value = v;
        dp_in = d;
        blank_lz = b;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 8;
        if (an !== 4'b0000) begin errors++; $display("FAIL reset_an got %b exp 0000", an); end
        if (seg_7 !== 7'b0000000) begin errors++; $display("FAIL reset_seg got %b exp 0000000", seg_7); end
        if (dp !== 1'b0) begin errors++; $display("FAIL reset_dp got %b exp 0", dp); end
        if (digit_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", digit_tick); end
        if (an_ca !== 4'b1111) begin errors++; $display("FAIL reset_an_ca got %b exp 1111", an_ca); end
        if (seg_ca !== 7'b1111111) begin errors++; $display("FAIL reset_seg_ca got %b exp 1111111", seg_ca); end
        if (dp_ca !== 1'b1) begin errors++; $display("FAIL reset_dp_ca got %b exp 1", dp_ca); end
        if (tick_ca !== 1'b0) begin errors++; $display("FAIL reset_tick_ca got %b exp 0", tick_ca); end
    endtask

    task automatic test_scan();
        logic [6:0] seg_e [4];
        logic [3:0] an_e [4];
        int d;
        seg_e = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
        an_e  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        apply_reset(16'h1234, 4'b0010, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            d = (k / 4) % 4;
            checks += 4;
            if (an !== an_e[d]) begin errors++; $display("FAIL scan_an k=%0d got %b exp %b", k, an, an_e[d]); end
            if (seg_7 !== seg_e[d]) begin errors++; $display("FAIL scan_seg k=%0d got %b exp %b", k, seg_7, seg_e[d]); end
            if (dp !== (d == 1)) begin errors++; $display("FAIL scan_dp k=%0d got %b exp %b", k, dp, d == 1); end
            if (digit_tick !== (k % 4 == 0)) begin errors++; $display("FAIL scan_tick k=%0d got %b exp %b", k, digit_tick, k % 4 == 0); end
        end
    endtask

    task automatic test_blank();
        logic [6:0] seg_e [4];
        logic [3:0] an_e [4];
        logic       dp_e [4];
        int d;
        seg_e = '{7'b1111110, 7'b1011011, 7'b0000000, 7'b0000000};
        an_e  = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};
        dp_e  = '{1'b1, 1'b1, 1'b0, 1'b0};
        apply_reset(16'h0050, 4'b1111, 1'b1);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            d = k / 4;
            checks += 3;
            if (an !== an_e[d]) begin errors++; $display("FAIL blank_an k=%0d got %b exp %b", k, an, an_e[d]); end
            if (seg_7 !== seg_e[d]) begin errors++; $display("FAIL blank_seg k=%0d got %b exp %b", k, seg_7, seg_e[d]); end
            if (dp !== dp_e[d]) begin errors++; $display("FAIL blank_dp k=%0d got %b exp %b", k, dp, dp_e[d]); end
        end
        apply_reset(16'h0000, 4'b0000, 1'b1);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            checks += 2;
            if (an !== ((k < 4) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL zero_an k=%0d got %b", k, an); end
            if (seg_7 !== ((k < 4) ? 7'b1111110 : 7'b0000000)) begin errors++; $display("FAIL zero_seg k=%0d got %b", k, seg_7); end
        end
    endtask

    task automatic test_no_tearing();
        logic [6:0] seg_e [8];
        logic [3:0] an_e [4];
        int d;
        seg_e = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000,
                  7'b0111101, 7'b1001110, 7'b0011111, 7'b1110111};
        an_e  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        apply_reset(16'h1234, 4'b0000, 1'b0);
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            #1;
            if (k == 9) value = 16'hABCD;
            if (k >= 8) begin
                d = k / 4;
                checks += 2;
                if (an !== an_e[d % 4]) begin errors++; $display("FAIL tear_an k=%0d got %b exp %b", k, an, an_e[d % 4]); end
                if (seg_7 !== seg_e[d]) begin errors++; $display("FAIL tear_seg k=%0d got %b exp %b", k, seg_7, seg_e[d]); end
            end
        end
    endtask

    task automatic test_enable();
        apply_reset(16'h1234, 4'b0000, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (an !== 4'b0010) begin errors++; $display("FAIL en_pre_an got %b exp 0010", an); end
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            checks += 3;
            if (an !== 4'b0000) begin errors++; $display("FAIL en_off_an k=%0d got %b exp 0000", k, an); end
            if (seg_7 !== 7'b0000000) begin errors++; $display("FAIL en_off_seg k=%0d got %b", k, seg_7); end
            if (digit_tick !== 1'b0) begin errors++; $display("FAIL en_off_tick k=%0d got %b", k, digit_tick); end
        end
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks += 3;
            if (an !== ((k < 2) ? 4'b0010 : 4'b0100)) begin errors++; $display("FAIL en_resume_an k=%0d got %b", k, an); end
            if (seg_7 !== ((k < 2) ? 7'b1111001 : 7'b1101101)) begin errors++; $display("FAIL en_resume_seg k=%0d got %b", k, seg_7); end
            if (digit_tick !== (k == 2)) begin errors++; $display("FAIL en_resume_tick k=%0d got %b exp %b", k, digit_tick, k == 2); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(16'h1234, 4'b0000, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (an !== 4'b0100) begin errors++; $display("FAIL rmid_pre_an got %b exp 0100", an); end
        #2;
        rst = 1'b1;
        value = 16'h5678;
        #1;
        checks += 3;
        if (an !== 4'b0000) begin errors++; $display("FAIL rmid_async_an got %b exp 0000", an); end
        if (seg_7 !== 7'b0000000) begin errors++; $display("FAIL rmid_async_seg got %b", seg_7); end
        if (digit_tick !== 1'b0) begin errors++; $display("FAIL rmid_async_tick got %b", digit_tick); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks += 3;
            if (an !== ((k < 4) ? 4'b0001 : 4'b0010)) begin errors++; $display("FAIL rmid_an k=%0d got %b", k, an); end
            if (seg_7 !== ((k < 4) ? 7'b1111111 : 7'b1110000)) begin errors++; $display("FAIL rmid_seg k=%0d got %b", k, seg_7); end
            if (digit_tick !== (k == 0 || k == 4)) begin errors++; $display("FAIL rmid_tick k=%0d got %b", k, digit_tick); end
        end
    endtask

    task automatic test_common_anode();
        apply_reset(16'h0008, 4'b0000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                checks += 5;
                if (an_ca !== 4'b1110) begin errors++; $display("FAIL ca_an got %b exp 1110", an_ca); end
                if (seg_ca !== 7'b0000000) begin errors++; $display("FAIL ca_seg got %b exp 0000000", seg_ca); end
                if (dp_ca !== 1'b1) begin errors++; $display("FAIL ca_dp got %b exp 1", dp_ca); end
                if (tick_ca !== 1'b1) begin errors++; $display("FAIL ca_tick got %b exp 1", tick_ca); end
                if (seg_7 !== 7'b1111111) begin errors++; $display("FAIL ca_ref_seg got %b exp 1111111", seg_7); end
            end
            if (k == 4) begin
                checks += 2;
                if (an_ca !== 4'b1101) begin errors++; $display("FAIL ca_an1 got %b exp 1101", an_ca); end
                if (seg_ca !== 7'b0000001) begin errors++; $display("FAIL ca_seg1 got %b exp 0000001", seg_ca); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank();
        test_no_tearing();
        test_enable();
        test_reset_mid();
        test_common_anode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_7_mux.md
SEG_7_MUX -- requirements
Module: seg_7_mux

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits (2..8).
REQ-002 Parameter REFRESH_DIV, default 1000: enabled clk cycles per digit slot (>=2).
REQ-003 Parameter COMMON_ANODE, default 0: 0 = active-high segments/anodes, 1 = all outputs inverted (active-low).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  scan enable; 0 freezes the scan and turns the display off.
REQ-007 value  input  4*N_DIGITS  hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost.
REQ-008 dp_in  input  N_DIGITS  decimal-point request per digit.
REQ-009 blank_lz  input  1  1 = blank leading zero digits.
REQ-010 seg_7  output  7  segments {a,b,c,d,e,f,g}, bit 6 = a, registered.
REQ-011 dp  output  1  decimal point of the active digit, registered.
REQ-012 an  output  N_DIGITS  one-hot digit select, bit i = digit i, registered.
REQ-013 digit_tick  output  1  one-cycle pulse, registered, high in the first cycle a new digit is shown.

Function
REQ-014 Prescaler counts 0..REFRESH_DIV-1 on cycles with en=1; at REFRESH_DIV-1 it wraps to 0 and the digit index advances.
REQ-015 Digit index counts 0..N_DIGITS-1, wraps to 0; en=0 holds prescaler and index unchanged.
REQ-016 Snapshot register (4*N_DIGITS bits + N_DIGITS dp bits + blank_lz) loads value/dp_in/blank_lz on the cycle the index wraps N_DIGITS-1 -> 0, and on the first en=1 cycle after reset; no other loads (no tearing within a scan).
REQ-017 Hex decode (active-high form): 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1111011 A=1110111 b=0011111 C=1001110 d=0111101 E=1001111 F=1000111.
REQ-018 Digit i is blanked when snapshot blank_lz=1, i>0, and all snapshot nibbles i..N_DIGITS-1 are 0; digit 0 is never blanked.
REQ-019 Blanked digit: an bit deasserted, seg_7=0000000, dp=0 (active-high form) for its whole slot; slot timing unchanged.
REQ-020 Outputs are registered from the current index and snapshot: they change exactly one clk after the index changes; digit_tick asserts in that same cycle.
REQ-021 en=0: on the next edge an, seg_7, dp go to inactive levels and digit_tick=0; on en returning to 1 the held digit is shown again from the next edge, prescaler resumes from its held count.
REQ-022 COMMON_ANODE=1 inverts seg_7, dp and an after all other logic; digit_tick is never inverted.
REQ-023 Exactly one an bit active at any time when en=1 and the digit is not blanked, otherwise none.

Reset
REQ-024 rst=1 immediately forces prescaler=0, index=0, snapshot=0, load-pending flag=1, digit_tick=0.
REQ-025 During reset an, seg_7, dp are at inactive levels: 0 for COMMON_ANODE=0, all ones for COMMON_ANODE=1.
REQ-026 rst asserted mid-scan aborts the scan; after release the first enabled edge loads the snapshot and shows digit 0.

Verification (N_DIGITS=4, REFRESH_DIV=4, COMMON_ANODE=0 unless stated)
REQ-027 value=16'h1234, blank_lz=0, en=1 -> an=0001/seg 0110011, then 0010/1111001, 0100/1101101, 1000/0110000, each held 4 cycles, digit_tick once per slot.
REQ-028 value=16'h0050, blank_lz=1 -> digits 3,2 an bit off and seg 0000000; digit 1 seg 1011011; digit 0 seg 1111110; value=0 shows only digit 0.
REQ-029 value changes 1234->ABCD while digit 2 is shown -> digit 3 still shows 1 (0110000); the next scan shows D,C,b,A.
REQ-030 en=0 for 10 cycles during digit 1 slot at count 2 -> an=0000 next edge; after en=1 digit 1 resumes and lasts exactly 2 more cycles.
REQ-031 rst pulse mid-slot of digit 2 -> outputs 0 asynchronously; after release digit 0 shown first with a fresh snapshot.
REQ-032 COMMON_ANODE=1, value=16'h0008 -> during reset an=1111, seg_7=1111111; digit 0 shows an=1110, seg_7=0000000, dp=1 when dp_in=0.
